// File: rtl/seq_alu_if.sv
// Request/response bundle between a host driver and the sequential add/sub datapath.
interface seq_alu_if #(
    parameter int unsigned WORDSIZE = 64,
    parameter int unsigned ADDR_W   = 5
);
    logic                start;
    logic [WORDSIZE-1:0] num1;
    logic [WORDSIZE-1:0] num2;
    logic                operation_in;
    logic [ADDR_W-1:0]   addr_a;
    logic [ADDR_W-1:0]   addr_b;
    logic [ADDR_W-1:0]   addr_dst;
    logic [ADDR_W-1:0]   rd_addr;
    logic [WORDSIZE-1:0] rd_data;
    logic                busy;
    logic                done;
    logic [WORDSIZE-1:0] result;
    logic                overflow;

    modport master (
        output start, num1, num2, operation_in, addr_a, addr_b, addr_dst, rd_addr,
        input  rd_data, busy, done, result, overflow
    );

    modport slave (
        input  start, num1, num2, operation_in, addr_a, addr_b, addr_dst, rd_addr,
        output rd_data, busy, done, result, overflow
    );
endinterface

// File: rtl/seq_alu_datapath.sv
// Restartable sequencer: stages operands through a data memory into a register file,
// performs a signed add/sub, writes the result back and reports it with overflow.
module seq_alu_datapath #(
    parameter int unsigned WORDSIZE = 64,
    parameter int unsigned SIZE     = 32,
    parameter int unsigned ADDR_W   = 5
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_alu_if.slave  bus
);
    typedef logic [WORDSIZE-1:0] word_t;
    typedef logic [ADDR_W-1:0]   addr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DM_WR_A,
        S_RF_LD_A,
        S_DM_WR_B,
        S_RF_LD_B,
        S_EXEC,
        S_WB,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    word_t dm [SIZE];
    word_t rf [SIZE];

    word_t num1_q, num2_q;
    logic  op_q;
    addr_t addr_a_q, addr_b_q, addr_dst_q;

    logic  busy_q, done_q, ovf_q;
    word_t result_q;

    logic  capture, exec_en;
    logic  dm_we, rf_we;
    addr_t dm_waddr, rf_waddr;
    word_t dm_wdata, rf_wdata;

    word_t dm_rd_a, dm_rd_b, rf_a, rf_b;
    word_t alu_res;
    logic  alu_ovf;

    // Slots at or beyond SIZE exist in the address space but not in the arrays.
    function automatic logic in_range(input addr_t addr);
        return 32'(addr) < SIZE;
    endfunction

    assign dm_rd_a = in_range(addr_a_q) ? dm[addr_a_q] : '0;
    assign dm_rd_b = in_range(addr_b_q) ? dm[addr_b_q] : '0;
    assign rf_a    = in_range(addr_a_q) ? rf[addr_a_q] : '0;
    assign rf_b    = in_range(addr_b_q) ? rf[addr_b_q] : '0;

    assign bus.rd_data  = in_range(bus.rd_addr) ? rf[bus.rd_addr] : '0;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.overflow = ovf_q;

    // Signed add/sub; overflow when the result sign disagrees with a same-signed effective pair.
    always_comb begin
        alu_res = op_q ? (rf_a - rf_b) : (rf_a + rf_b);
        if (op_q)
            alu_ovf = (rf_a[WORDSIZE-1] != rf_b[WORDSIZE-1]) && (alu_res[WORDSIZE-1] != rf_a[WORDSIZE-1]);
        else
            alu_ovf = (rf_a[WORDSIZE-1] == rf_b[WORDSIZE-1]) && (alu_res[WORDSIZE-1] != rf_a[WORDSIZE-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            num1_q     <= '0;
            num2_q     <= '0;
            op_q       <= 1'b0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            addr_dst_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
            if (capture) begin
                num1_q     <= bus.num1;
                num2_q     <= bus.num2;
                op_q       <= bus.operation_in;
                addr_a_q   <= bus.addr_a;
                addr_b_q   <= bus.addr_b;
                addr_dst_q <= bus.addr_dst;
            end
            if (exec_en) begin
                result_q <= alu_res;
                ovf_q    <= alu_ovf;
            end
        end
    end

    // One state per cycle; array write ports are steered by the current state.
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        exec_en  = 1'b0;
        dm_we    = 1'b0;
        dm_waddr = addr_a_q;
        dm_wdata = num1_q;
        rf_we    = 1'b0;
        rf_waddr = addr_a_q;
        rf_wdata = dm_rd_a;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    capture = 1'b1;
                    state_d = S_DM_WR_A;
                end
            end
            S_DM_WR_A: begin
                dm_we   = in_range(addr_a_q);
                state_d = S_RF_LD_A;
            end
            S_RF_LD_A: begin
                rf_we   = in_range(addr_a_q);
                state_d = S_DM_WR_B;
            end
            S_DM_WR_B: begin
                dm_we    = in_range(addr_b_q);
                dm_waddr = addr_b_q;
                dm_wdata = num2_q;
                state_d  = S_RF_LD_B;
            end
            S_RF_LD_B: begin
                rf_we    = in_range(addr_b_q);
                rf_waddr = addr_b_q;
                rf_wdata = dm_rd_b;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                exec_en = 1'b1;
                state_d = S_WB;
            end
            S_WB: begin
                rf_we    = in_range(addr_dst_q);
                rf_waddr = addr_dst_q;
                rf_wdata = result_q;
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Array storage carries no reset; contents survive an abort.
    always_ff @(posedge clk) begin
        if (dm_we) dm[dm_waddr] <= dm_wdata;
        if (rf_we) rf[rf_waddr] <= rf_wdata;
    end
endmodule

// File: tb/tb_seq_alu_datapath.sv
// Randomised scoreboard bench for seq_alu_datapath with a reduced SIZE so that
// out-of-range slots are exercised.
module tb_seq_alu_datapath;
    localparam int unsigned W      = 64;
    localparam int unsigned ASIZE  = 28;
    localparam int unsigned AW     = 5;
    localparam logic signed [64:0] MAXP = 65'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [64:0] MINN = -MAXP - 65'sd1;

    logic clk;
    logic rst_n;

    seq_alu_if #(.WORDSIZE(W), .ADDR_W(AW)) bus ();

    seq_alu_datapath #(.WORDSIZE(W), .SIZE(ASIZE), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] res;
        logic        ovf;
        logic [4:0]  dst;
        logic [63:0] rd;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [63:0] dm_m [32];
    logic [63:0] rf_m [32];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: memory-level walk of one request using wide signed arithmetic.
    function automatic exp_t model(input logic [63:0] n1, input logic [63:0] n2, input logic op,
                                   input logic [4:0] a, input logic [4:0] b, input logic [4:0] dst);
        exp_t e;
        logic [63:0] va, vb;
        logic signed [64:0] w;
        if (a < ASIZE) begin dm_m[a] = n1; rf_m[a] = dm_m[a]; end
        if (b < ASIZE) begin dm_m[b] = n2; rf_m[b] = dm_m[b]; end
        va = (a < ASIZE) ? rf_m[a] : 64'd0;
        vb = (b < ASIZE) ? rf_m[b] : 64'd0;
        w  = op ? ($signed({va[63], va}) - $signed({vb[63], vb}))
                : ($signed({va[63], va}) + $signed({vb[63], vb}));
        e.res = w[63:0];
        e.ovf = (w > MAXP) || (w < MINN);
        if (dst < ASIZE) rf_m[dst] = e.res;
        e.dst = dst;
        e.rd  = (dst < ASIZE) ? e.res : 64'd0;
        e.acc = 0;
        return e;
    endfunction

    function automatic logic [63:0] rnd_word();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = 64'h7FFF_FFFF_FFFF_FFFF;
            1:       v = 64'h8000_0000_0000_0000;
            2:       v = 64'd0;
            3:       v = '1;
            default: v = {32'($urandom), 32'($urandom)};
        endcase
        return v;
    endfunction

    task automatic issue(input logic [63:0] n1, input logic [63:0] n2, input logic op,
                         input logic [4:0] a, input logic [4:0] b, input logic [4:0] dst,
                         input bit keep, output int acc);
        int   waited;
        exp_t e;
        waited = 0;
        acc    = -1;
        @(negedge clk);
        while (bus.busy && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (bus.busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: busy still %b after %0d cycles, required 0", bus.busy, waited);
            bus.start = 1'b0;
            return;
        end
        bus.num1         = n1;
        bus.num2         = n2;
        bus.operation_in = op;
        bus.addr_a       = a;
        bus.addr_b       = b;
        bus.addr_dst     = dst;
        bus.start        = 1'b1;
        e     = model(n1, n2, op, a, b, dst);
        e.acc = cyc + 1;
        acc   = e.acc;
        q.push_back(e);
        if (!keep) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
    endtask

    // Monitor: pops one expectation per done pulse, also checks latency and busy length.
    initial begin : monitor
        exp_t e;
        int   busy_run;
        busy_run    = 0;
        bus.rd_addr = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!rst_n) begin
                busy_run = 0;
                continue;
            end
            if (bus.busy) busy_run++;
            else if (busy_run != 0) begin
                chk("busy_len", 64'(busy_run), 64'd7);
                busy_run = 0;
            end
            if (bus.done) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_done: done=1 with no request pending (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("latency", 64'(cyc - e.acc), 64'd6);
                    chk("result", bus.result, e.res);
                    chk("overflow", 64'(bus.overflow), 64'(e.ovf));
                    bus.rd_addr = e.dst;
                    #1;
                    chk("rd_data", bus.rd_data, e.rd);
                end
            end
        end
    end

    initial begin : stimulus
        int acc;
        int waited;
        bus.start        = 1'b0;
        bus.num1         = '0;
        bus.num2         = '0;
        bus.operation_in = 1'b0;
        bus.addr_a       = '0;
        bus.addr_b       = '0;
        bus.addr_dst     = '0;
        rst_n            = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_result", bus.result, 64'd0);
        chk("reset_overflow", 64'(bus.overflow), 64'd0);

        issue(64'd5, 64'd7, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, acc);
        issue(64'd3, 64'd10, 1'b1, 5'd0, 5'd1, 5'd2, 1'b0, acc);
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 5'd3, 5'd6, 5'd7, 1'b0, acc);
        issue(64'h8000_0000_0000_0000, 64'd1, 1'b1, 5'd3, 5'd6, 5'd7, 1'b0, acc);
        issue(64'd9, 64'd2, 1'b0, 5'd4, 5'd4, 5'd5, 1'b0, acc);
        issue(64'd9, 64'd2, 1'b0, 5'd4, 5'd4, 5'd4, 1'b0, acc);
        issue(64'd100, 64'd1, 1'b1, 5'd30, 5'd8, 5'd29, 1'b0, acc);

        // start pulsed while busy must not launch a second operation
        issue(64'd40, 64'd2, 1'b0, 5'd10, 5'd11, 5'd12, 1'b0, acc);
        @(negedge clk);
        bus.num1  = 64'd999;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;

        // start held high: one operation every 8 cycles
        for (int i = 0; i < 5; i++)
            issue(rnd_word(), rnd_word(), 1'($urandom_range(0, 1)), 5'(i), 5'(i + 8), 5'(i + 16),
                  (i != 4), acc);

        // abort in the execute cycle
        issue(64'd50, 64'd20, 1'b1, 5'd13, 5'd14, 5'd15, 1'b0, acc);
        waited = 0;
        while (cyc < acc + 4 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_result", bus.result, 64'd0);
        chk("abort_overflow", 64'(bus.overflow), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(64'd50, 64'd20, 1'b1, 5'd13, 5'd14, 5'd15, 1'b0, acc);

        for (int i = 0; i < 60; i++) begin
            issue(rnd_word(), rnd_word(), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 2) == 0) && (i != 59), acc);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        waited = 0;
        while ((q.size() != 0 || bus.busy) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d results outstanding, required 0", q.size());
        end
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
